uart_rx: RTL

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_pkg.sv | 18 +
 rtl/uart_sync2.sv | 30 +++
 rtl/uart_rx.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared constants and types for the UART receiver slice.
//   DATA_W           - width of a received character (8)
//   CLKS_PER_BIT_DEF - default clk cycles per serial bit
//   state_t          - receiver FSM state encoding
package uart_pkg;

  localparam int DATA_W           = 8;
  localparam int CLKS_PER_BIT_DEF = 16;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_IDLE = 3'd4
  } state_t;

endpackage

// File: rtl/uart_sync2.sv
// uart_sync2: two-flop synchronizer for an asynchronous level, reset to 1
// so an idle-high serial line never looks like a start bit after reset.
//   clk   - destination clock
//   reset - synchronous, active-high; forces both flops to 1
//   d     - asynchronous input
//   q     - synchronized output
module uart_sync2 (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic sync_p0;
  logic sync_p1;

  // stage 0 -> stage 1 synchronizer chain
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_p0 <= 1'b1;
      sync_p1 <= 1'b1;
    end else begin
      sync_p0 <= d;
      sync_p1 <= sync_p0;
    end
  end

  assign q = sync_p1;

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with a one-entry output register and
// valid/ready handshake.
//   clk       - single clock, rising edge
//   reset     - synchronous, active-high
//   pin       - asynchronous serial input, idle high, LSB first
//   data      - received byte, held while valid
//   valid     - data holds an unconsumed byte
//   ready     - consumer takes data when valid && ready
//   frame_err - one-cycle pulse when the stop bit is sampled low
//   overrun   - sticky until reset; a completed byte was dropped
//   busy      - receiver is not in IDLE
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pin,
  output logic [DATA_W-1:0] data,
  output logic              valid,
  input  logic              ready,
  output logic              frame_err,
  output logic              overrun,
  output logic              busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_W);
  // Counters count down to zero; loading N-1 gives a sample N cycles later.
  localparam logic [CW-1:0] HALF_LD  = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_LD  = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] LAST_BIT = IW'(DATA_W - 1);

  logic              rx_s;
  state_t            state;
  state_t            state_nxt;
  logic [CW-1:0]     baud_cnt;
  logic [IW-1:0]     bit_idx;
  logic [DATA_W-1:0] shift;

  logic cnt_zero;
  logic ld_half;
  logic ld_full;
  logic take_bit;
  logic deliver;
  logic ferr_set;

  uart_sync2 u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (pin),
    .q     (rx_s)
  );

  assign cnt_zero = (baud_cnt == '0);
  assign busy     = (state != IDLE);

  always_comb begin
    state_nxt = state;
    ld_half   = 1'b0;
    ld_full   = 1'b0;
    take_bit  = 1'b0;
    deliver   = 1'b0;
    ferr_set  = 1'b0;
    case (state)
      IDLE: begin
        if (!rx_s) begin
          state_nxt = START;
          ld_half   = 1'b1;
        end
      end
      START: begin
        if (cnt_zero) begin
          if (!rx_s) begin
            state_nxt = DATA;
            ld_full   = 1'b1;
          end else begin
            // Line back high at mid-start: treat as a glitch.
            state_nxt = IDLE;
          end
        end
      end
      DATA: begin
        if (cnt_zero) begin
          take_bit = 1'b1;
          ld_full  = 1'b1;
          if (bit_idx == LAST_BIT) state_nxt = STOP;
        end
      end
      STOP: begin
        if (cnt_zero) begin
          if (rx_s) begin
            deliver   = 1'b1;
            state_nxt = IDLE;
          end else begin
            ferr_set  = 1'b1;
            state_nxt = WAIT_IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        // A held-low break parks here, so it reports only one frame error.
        if (rx_s) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // FSM state, baud and bit counters
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
    end else begin
      state <= state_nxt;
      if (ld_half)       baud_cnt <= HALF_LD;
      else if (ld_full)  baud_cnt <= FULL_LD;
      else if (!cnt_zero) baud_cnt <= baud_cnt - CW'(1);
      if (state == IDLE)  bit_idx <= '0;
      else if (take_bit) bit_idx <= bit_idx + IW'(1);
    end
  end

  // Shift register is pure datapath; IDLE restarts the index each frame.
  always_ff @(posedge clk) begin
    if (take_bit) shift[bit_idx] <= rx_s;
  end

  // Output register: one entry, loads when empty or drained this cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      data      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= ferr_set;
      if (deliver) begin
        if (!valid || ready) begin
          data  <= shift;
          valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (valid && ready) begin
        valid <= 1'b0;
      end
    end
  end

endmodule
